// File: rtl/mult_ctrl_if.sv
// Handshake and result bundle for the mult_ctrl sequential multiplier.
interface mult_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, is_signed, a, b, input busy, done, hi, lo);
    modport slave  (input start, is_signed, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_ctrl.sv
// Iterative shift-add multiplier, one partial product per RUN cycle.
// Signed (MULT) support is compiled in only when SIGNED_MULT_EN is defined.
module mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mult_ctrl_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [1:0]      IDLE = 2'd0;
    localparam logic [1:0]      RUN  = 2'd1;
    localparam logic [1:0]      DONE = 2'd2;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
`ifdef SIGNED_MULT_EN
    logic               neg_q,    neg_d;
`endif

    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] res_s;

`ifdef SIGNED_MULT_EN
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
        if (en && v[WIDTH-1]) begin
            return ~v + WIDTH'(1);
        end else begin
            return v;
        end
    endfunction
`endif

    // One shift-add step: the adder carry becomes the new MSB of the shifted pair.
    always_comb begin
        if (mplier_q[0]) begin
            sum_s = {1'b0, acc_q} + {1'b0, mcand_q};
        end else begin
            sum_s = {1'b0, acc_q};
        end
        prod_s = {sum_s, mplier_q[WIDTH-1:1]};
`ifdef SIGNED_MULT_EN
        res_s = neg_q ? (~prod_s + (2*WIDTH)'(1)) : prod_s;
`else
        res_s = prod_s;
`endif
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
`ifdef SIGNED_MULT_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
`ifdef SIGNED_MULT_EN
                    mcand_d  = magnitude(bus.a, bus.is_signed);
                    mplier_d = magnitude(bus.b, bus.is_signed);
                    neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`else
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
`endif
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = prod_s[2*WIDTH-1:WIDTH];
                mplier_d = prod_s[WIDTH-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    hi_d    = res_s[2*WIDTH-1:WIDTH];
                    lo_d    = res_s[WIDTH-1:0];
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SIGNED_MULT_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SIGNED_MULT_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
